// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the core run sequencer.
package run_ctrl_pkg;

    // Debug encoding of the sequencer state, visible on the state port.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        GO     = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } run_state_e;

    // jal x0,0 : a self-loop that test programs park on when finished.
    localparam logic [31:0] JAL_SELF_LOOP = 32'h0000_006F;

    // Used to size the shared SETTLE/DRAIN phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/up_counter.sv
// Free-running up counter with synchronous clear and count enable.
module up_counter #(
    parameter int WIDTH          = 32,
    parameter int INCREMENT_RATE = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    // Clear wins over enable; the count wraps modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(INCREMENT_RATE);
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer for CoreTop: gates the core clock, fires the first fetch,
// watches for the halt self-loop or a watchdog expiry, then drains and
// reports done/timeout/aborted along with the number of RUN cycles.
module core_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          CYCLE_CNT_W     = 32,
    parameter int          WATCHDOG_CYCLES = 5000,
    parameter int          SETTLE_CYCLES   = 10,
    parameter int          DRAIN_CYCLES    = 10,
    parameter logic [31:0] HALT_INSTR      = JAL_SELF_LOOP
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            decode_instruction,
    output logic                   cg_clk_en,
    output logic                   first_fetch_trigger,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic                   aborted,
    output logic [CYCLE_CNT_W-1:0] cycle_count,
    output logic [2:0]             state
);

    // SETTLE and DRAIN never overlap, so one phase counter serves both.
    localparam int PH_MAX = max_int(SETTLE_CYCLES, DRAIN_CYCLES);
    localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
    localparam int WD_W   = (WATCHDOG_CYCLES < 2) ? 1 : $clog2(WATCHDOG_CYCLES);

    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST  = PH_W'(DRAIN_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(WATCHDOG_CYCLES - 1);

    run_state_e      state_q, state_d;
    logic [PH_W-1:0] ph_cnt, ph_d;
    logic [WD_W-1:0] wd_cnt, wd_d;
    logic            done_d, timeout_d, aborted_d;
    logic            cnt_clr;
    logic            is_halt;

    assign is_halt = (decode_instruction == HALT_INSTR);
    assign state   = state_q;

    // Next-state, counter and sticky-flag decisions; abort overrides last.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_cnt;
        wd_d      = wd_cnt;
        done_d    = done;
        timeout_d = timeout;
        aborted_d = aborted;
        cnt_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETTLE;
                    ph_d      = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            SETTLE: begin
                ph_d = ph_cnt + 1'b1;
                if (ph_cnt == SETTLE_LAST) begin
                    state_d = GO;
                end
            end
            GO: begin
                wd_d    = '0;
                state_d = RUN;
            end
            RUN: begin
                wd_d = wd_cnt + 1'b1;
                // Halt is checked first so it wins a tie with the watchdog.
                if (is_halt) begin
                    state_d = DRAIN;
                    ph_d    = '0;
                end else if (wd_cnt == WD_LAST) begin
                    state_d   = DRAIN;
                    ph_d      = '0;
                    timeout_d = 1'b1;
                end
            end
            DRAIN: begin
                ph_d = ph_cnt + 1'b1;
                if (ph_cnt == DRAIN_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort cuts any active phase short and skips DRAIN; a timeout
        // flagged earlier in the run stays, but one decided this cycle does not.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
            timeout_d = timeout;
        end
    end

    // State, counters and registered outputs; outputs follow the next state
    // so the clock gate and fetch pulse line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q             <= IDLE;
            ph_cnt              <= '0;
            wd_cnt              <= '0;
            cg_clk_en           <= 1'b0;
            first_fetch_trigger <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            timeout             <= 1'b0;
            aborted             <= 1'b0;
        end else begin
            state_q             <= state_d;
            ph_cnt              <= ph_d;
            wd_cnt              <= wd_d;
            cg_clk_en           <= (state_d != IDLE);
            first_fetch_trigger <= (state_d == GO);
            busy                <= (state_d != IDLE);
            done                <= done_d;
            timeout             <= timeout_d;
            aborted             <= aborted_d;
        end
    end

    // RUN-cycle counter: counts every RUN cycle including the exit cycle,
    // holds its value between runs, restarts when a new run is accepted.
    up_counter #(
        .WIDTH          (CYCLE_CNT_W),
        .INCREMENT_RATE (1)
    ) u_cycle_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .en    (state_q == RUN),
        .clear (cnt_clr),
        .count (cycle_count)
    );

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Synthesizable run sequencer for CoreTop. It owns the core clock-gate enable and the first-fetch pulse, and detects end-of-program. It also enforces a watchdog limit and counts execution cycles. The block sits beside CoreTop on the free-running clock and drives the ClockGate enable and CoreTop.first_fetch_trigger. This lets one start request run a loaded program and report done or timeout.

Parameters:
CYCLE_CNT_W, 32, width of cycle_count
WATCHDOG_CYCLES, 5000, maximum RUN cycles before forced stop (>=2)
SETTLE_CYCLES, 10, cycles with core clock enabled before first fetch (>=1)
DRAIN_CYCLES, 10, cycles core clock stays enabled after stop decision (>=1)
HALT_INSTR, 32'h0000006F, decode-stage instruction that marks end of test (jal x0,0)

Ports:
clk  in  1  free-running clock (ungated side of ClockGate)
rstn  in  1  reset, synchronous, active-low
start  in  1  run request; sampled only in IDLE
abort  in  1  forced stop; effective in any non-IDLE state
decode_instruction  in  32  CoreTop decode-stage instruction
cg_clk_en  out  1  ClockGate enable for core clock
first_fetch_trigger  out  1  one-cycle pulse to CoreTop
busy  out  1  high in any state except IDLE
done  out  1  sticky; set on return to IDLE, cleared by next accepted start
timeout  out  1  sticky; run ended by watchdog
aborted  out  1  sticky; run ended by abort
cycle_count  out  CYCLE_CNT_W  RUN cycles of last/current run
state  out  3  debug encoding of FSM state

Behaviour:
- All outputs are registered. Reset (rstn=0 at a clk edge): state=IDLE, and all outputs and internal counters are 0.
- The FSM has states IDLE, SETTLE, GO, RUN, DRAIN. A single phase counter ph_cnt is used by SETTLE and DRAIN. A watchdog counter wd_cnt is used by RUN.
- IDLE: cg_clk_en=0.
  - start=1 moves to SETTLE and sets ph_cnt=0.
  - The same transition clears done, timeout, aborted and cycle_count.
- SETTLE: cg_clk_en=1. ph_cnt increments each cycle. When ph_cnt==SETTLE_CYCLES-1, the FSM moves to GO.
- GO: exactly one cycle.
  - first_fetch_trigger=1 and cg_clk_en=1.
  - wd_cnt is set to 0, then the FSM moves to RUN.
- RUN: cg_clk_en=1. cycle_count and wd_cnt increment every cycle, including the exit cycle.
  - If decode_instruction==HALT_INSTR, the FSM moves to DRAIN.
  - Otherwise, if wd_cnt==WATCHDOG_CYCLES-1, it moves to DRAIN and sets timeout=1.
  - When both conditions hold in the same cycle, halt wins and timeout stays 0.
  - cycle_count wraps modulo 2^CYCLE_CNT_W and is frozen outside RUN.
- DRAIN: cg_clk_en=1. ph_cnt restarts at 0. When ph_cnt==DRAIN_CYCLES-1, the FSM moves to IDLE and sets done=1. cg_clk_en=0 from the first IDLE cycle.
- Latency: with start sampled at edge N, cg_clk_en rises after N and first_fetch_trigger is high for the cycle after edge N+SETTLE_CYCLES.
- abort=1 in SETTLE, GO, RUN or DRAIN moves to IDLE next edge.
  - That transition sets done=1 and aborted=1 and drops cg_clk_en.
  - abort takes priority over halt and watchdog in the same cycle.
  - abort in IDLE is ignored.
- start outside IDLE is ignored.
- start and abort both high in IDLE: the start is accepted and the abort is ignored.
- Reset asserted mid-run returns the block to IDLE with cg_clk_en=0 on the same edge. Sticky flags are cleared.
- decode_instruction is examined only in RUN. A HALT_INSTR value present during SETTLE or GO has no effect.

Decomposition:
- run_ctrl_pkg:
  - state enum run_state_e {IDLE=0, SETTLE=1, GO=2, RUN=3, DRAIN=4}
  - JAL_SELF_LOOP constant 32'h0000006F, used as the HALT_INSTR default
- Sub-module: the existing UpCounter, WIDTH=CYCLE_CNT_W, INCREMENT_RATE=1, used for cycle_count.
  - en is tied to (state==RUN); clear is tied to the IDLE->SETTLE transition.
  - The FSM and the ph_cnt/wd_cnt counters stay inline.

Test Plan:
- Defaults. start pulsed at cycle 0; HALT_INSTR presented on the 25th RUN cycle. Expected:
  - cg_clk_en=1 from cycle 1.
  - first_fetch_trigger high for exactly one cycle at cycle 11.
  - cycle_count=25.
  - done=1 and cg_clk_en=0 after 10 DRAIN cycles.
  - timeout=0 and aborted=0.
- WATCHDOG_CYCLES=50, halt never presented. Expected: exit after 50 RUN cycles, cycle_count=50, timeout=1, done=1.
- WATCHDOG_CYCLES=50, HALT_INSTR presented on RUN cycle 50. Expected: timeout=0 (halt priority) and cycle_count=50.
- abort pulsed on RUN cycle 7. Expected:
  - Next edge reaches IDLE with cg_clk_en=0, aborted=1, done=1.
  - cycle_count=7; no DRAIN phase.
- Second start after a completed run. Expected: done, timeout and aborted clear on acceptance, and cycle_count restarts from 0. A start during RUN or DRAIN is ignored.
- rstn=0 for one edge during SETTLE. Expected:
  - All outputs are 0 next cycle and first_fetch_trigger never pulses.
  - HALT_INSTR held during SETTLE does not end the subsequent run.
